// File: rtl/dircc_packet_router.sv
// Header-addressed packet router: steers whole Avalon-ST packets to the local
// port, the forward port or both, each through a one-deep registered stage.
module dircc_packet_router #(
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFFF,
    parameter logic [31:0] BCAST_ADDR  = 32'hFFFF_FFFF,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [31:0]            address_address,
    input  logic                   stream_in_valid,
    input  logic [31:0]            stream_in_data,
    input  logic                   stream_in_startofpacket,
    input  logic                   stream_in_endofpacket,
    input  logic [1:0]             stream_in_empty,
    output logic                   stream_in_ready,
    output logic                   stream_local_valid,
    output logic [31:0]            stream_local_data,
    output logic                   stream_local_startofpacket,
    output logic                   stream_local_endofpacket,
    output logic [1:0]             stream_local_empty,
    input  logic                   stream_local_ready,
    output logic                   stream_fwd_valid,
    output logic [31:0]            stream_fwd_data,
    output logic                   stream_fwd_startofpacket,
    output logic                   stream_fwd_endofpacket,
    output logic [1:0]             stream_fwd_empty,
    input  logic                   stream_fwd_ready,
    output logic [COUNT_WIDTH-1:0] pkt_local_count,
    output logic [COUNT_WIDTH-1:0] pkt_fwd_count,
    output logic [7:0]             err_count
);

    typedef enum logic [2:0] {S_IDLE, S_LOCAL, S_FWD, S_BCAST, S_DROP} state_t;

    state_t                 r_state, w_next_state;
    logic                   r_loc_valid, r_loc_sop, r_loc_eop;
    logic [31:0]            r_loc_data;
    logic [1:0]             r_loc_empty;
    logic                   r_fwd_valid, r_fwd_sop, r_fwd_eop;
    logic [31:0]            r_fwd_data;
    logic [1:0]             r_fwd_empty;
    logic [COUNT_WIDTH-1:0] r_pkt_local, r_pkt_fwd;
    logic [7:0]             r_err;

    logic w_dec_bcast, w_dec_local, w_dec_to_loc, w_dec_to_fwd;
    logic w_loc_free, w_fwd_free, w_need_loc, w_need_fwd;
    logic w_ready, w_accept, w_load_loc, w_load_fwd, w_err, w_start;

    assign w_dec_bcast  = (stream_in_data == BCAST_ADDR);
    assign w_dec_local  = ((stream_in_data & ADDR_MASK) == (address_address & ADDR_MASK));
    assign w_dec_to_loc = w_dec_bcast || w_dec_local;
    assign w_dec_to_fwd = w_dec_bcast || !w_dec_local;
    assign w_loc_free   = !r_loc_valid || stream_local_ready;
    assign w_fwd_free   = !r_fwd_valid || stream_fwd_ready;

    // Any SOP (including an erroneous one in DROP or mid-packet) is a new
    // header, so readiness follows its decoded targets, not the latched ones.
    always_comb begin
        w_need_loc   = 1'b0;
        w_need_fwd   = 1'b0;
        w_next_state = r_state;
        w_err        = 1'b0;
        if (stream_in_startofpacket) begin
            w_need_loc = w_dec_to_loc;
            w_need_fwd = w_dec_to_fwd;
        end else begin
            case (r_state)
                S_LOCAL: w_need_loc = 1'b1;
                S_FWD:   w_need_fwd = 1'b1;
                S_BCAST: begin
                    w_need_loc = 1'b1;
                    w_need_fwd = 1'b1;
                end
                default: ;
            endcase
        end
        w_ready    = !reset_reset && (!w_need_loc || w_loc_free) && (!w_need_fwd || w_fwd_free);
        w_accept   = stream_in_valid && w_ready;
        w_load_loc = w_accept && w_need_loc;
        w_load_fwd = w_accept && w_need_fwd;
        w_start    = w_accept && stream_in_startofpacket;
        if (w_accept) begin
            if (stream_in_startofpacket) begin
                w_err = (r_state != S_IDLE);
                if (stream_in_endofpacket) w_next_state = S_IDLE;
                else if (w_dec_bcast)      w_next_state = S_BCAST;
                else if (w_dec_local)      w_next_state = S_LOCAL;
                else                       w_next_state = S_FWD;
            end else if (r_state == S_IDLE) begin
                w_err        = 1'b1;
                w_next_state = stream_in_endofpacket ? S_IDLE : S_DROP;
            end else if (stream_in_endofpacket) begin
                w_next_state = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= S_IDLE;
            r_loc_valid <= 1'b0;
            r_loc_data  <= '0;
            r_loc_sop   <= 1'b0;
            r_loc_eop   <= 1'b0;
            r_loc_empty <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
            r_fwd_sop   <= 1'b0;
            r_fwd_eop   <= 1'b0;
            r_fwd_empty <= '0;
            r_pkt_local <= '0;
            r_pkt_fwd   <= '0;
            r_err       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_loc) begin
                r_loc_valid <= 1'b1;
                r_loc_data  <= stream_in_data;
                r_loc_sop   <= stream_in_startofpacket;
                r_loc_eop   <= stream_in_endofpacket;
                r_loc_empty <= stream_in_empty;
            end else if (stream_local_ready) begin
                r_loc_valid <= 1'b0;
            end
            if (w_load_fwd) begin
                r_fwd_valid <= 1'b1;
                r_fwd_data  <= stream_in_data;
                r_fwd_sop   <= stream_in_startofpacket;
                r_fwd_eop   <= stream_in_endofpacket;
                r_fwd_empty <= stream_in_empty;
            end else if (stream_fwd_ready) begin
                r_fwd_valid <= 1'b0;
            end
            if (w_start && w_dec_to_loc && (r_pkt_local != '1))
                r_pkt_local <= r_pkt_local + COUNT_WIDTH'(1);
            if (w_start && w_dec_to_fwd && (r_pkt_fwd != '1))
                r_pkt_fwd <= r_pkt_fwd + COUNT_WIDTH'(1);
            if (w_err && (r_err != '1))
                r_err <= r_err + 8'd1;
        end
    end

    assign stream_in_ready            = w_ready;
    assign stream_local_valid         = r_loc_valid;
    assign stream_local_data          = r_loc_data;
    assign stream_local_startofpacket = r_loc_sop;
    assign stream_local_endofpacket   = r_loc_eop;
    assign stream_local_empty         = r_loc_empty;
    assign stream_fwd_valid           = r_fwd_valid;
    assign stream_fwd_data            = r_fwd_data;
    assign stream_fwd_startofpacket   = r_fwd_sop;
    assign stream_fwd_endofpacket     = r_fwd_eop;
    assign stream_fwd_empty           = r_fwd_empty;
    assign pkt_local_count            = r_pkt_local;
    assign pkt_fwd_count              = r_pkt_fwd;
    assign err_count                  = r_err;

endmodule

// File: doc/dircc_packet_router.md
Name: dircc_packet_router

Overview:
- Routing-side stage directly downstream of the processing tile's packet output stream.
- Accepts one Avalon-ST 32-bit packet stream and steers each whole packet by the destination address in its header beat (first beat, SOP).
  - Local address match -> local port (back into the tile).
  - Broadcast address -> both local and forward ports.
  - Any other address -> forward port (toward the network).
- Each output has a one-deep registered stage; per-class packet and error counters are provided for debug.

Parameters:
ADDR_MASK, 32'hFFFF_FFFF, bits of the header compared against address_address; 0 bits are ignored.
BCAST_ADDR, 32'hFFFF_FFFF, header value (full 32 bits, unmasked) meaning deliver to both outputs.
COUNT_WIDTH, 16, width of the packet counters.

Ports:
clk_clk  in  1  single clock (routing domain)
reset_reset  in  1  synchronous active-high reset
address_address  in  32  this tile's address, treated as static
stream_in_valid  in  1  input beat valid
stream_in_data  in  32  input beat data; SOP beat = destination address
stream_in_startofpacket  in  1  first beat of packet
stream_in_endofpacket  in  1  last beat of packet
stream_in_empty  in  2  empty bytes on EOP beat
stream_in_ready  out  1  input beat accepted when valid&ready
stream_local_valid/data/startofpacket/endofpacket/empty  out  1/32/1/1/2  local output stream
stream_local_ready  in  1  local sink ready
stream_fwd_valid/data/startofpacket/endofpacket/empty  out  1/32/1/1/2  forward output stream
stream_fwd_ready  in  1  forward sink ready
pkt_local_count  out  COUNT_WIDTH  packets whose SOP went local (including broadcast), saturating
pkt_fwd_count  out  COUNT_WIDTH  packets whose SOP went forward (including broadcast), saturating
err_count  out  8  protocol errors, saturating at 255

Behaviour:
- Handshake: Avalon-ST, readyLatency 0, on input and outputs. Outputs are registered; latency from input accept to output valid is 1 cycle.
- Output register state: each output has a holding register plus valid flag.
  - A register is free-or-freeing when valid==0 or its ready==1 this cycle.
- stream_in_ready rules (combinational from state, header decode, free flags):
  - IDLE: header targets only.
  - Broadcast: both registers must be free-or-freeing.
  - DROP: always 1.
- States:
  - IDLE: awaiting SOP.
    - Accepted SOP beat: compute dest = stream_in_data.
      - dest==BCAST_ADDR -> BCAST.
      - (dest&ADDR_MASK)==(address_address&ADDR_MASK) -> LOCAL.
      - Otherwise -> FWD.
      - BCAST is checked first.
    - The header beat itself is delivered to the selected output(s).
    - An SOP beat that also has EOP returns to IDLE the same cycle.
    - Accepted non-SOP beat in IDLE: discard, err_count+1, go DROP (or stay IDLE if that beat had EOP).
  - LOCAL / FWD / BCAST: pass beats unchanged (data, sop, eop, empty) to the latched target(s). Accepted EOP beat -> IDLE.
  - DROP: discard all beats. Accepted EOP -> IDLE. Accepted SOP -> err_count+1 and handle as in IDLE (re-decode).
- SOP inside LOCAL/FWD/BCAST: err_count+1.
  - The beat is treated as a new header and re-decoded; the previous packet is truncated and no EOP is synthesised.
- Counters increment on the accepted SOP beat that starts a routed packet; broadcast increments both packet counters. All counters saturate and never wrap.
- Simultaneous events: an output register may drain and reload in the same cycle, giving full throughput of 1 beat/cycle per port with sink ready held high.
- Back-pressure: the holding registers are never overwritten while valid && !ready.
- Reset: synchronous, highest priority. On reset:
  - State = IDLE.
  - Both output valids = 0; data/sop/eop/empty = 0.
  - All counters = 0.
  - stream_in_ready = 0 during the reset cycle.
  - A packet in flight at reset is abandoned; post-reset beats without SOP follow the IDLE error rule.

Test Plan:
- address_address=0x0000_0005; packet [0x5, 0xA1, 0xA2 EOP empty=2], both readys=1 -> 3 beats appear on local only, 1 cycle later, back-to-back, empty=2 on last; pkt_local_count=1; fwd_valid never 1.
- Packet [0x9, 0xB1 EOP] -> forward only; pkt_fwd_count=1. With ADDR_MASK=0xFFFF_FFF0 and address 0x5, header 0x9 goes local instead.
- Broadcast [0xFFFF_FFFF, 0xC1 EOP], fwd_ready low 4 cycles -> stream_in_ready=0 while the fwd register is occupied; both ports each receive both beats exactly once; both counters = 1.
- Stray beat 0xDEAD (no SOP) then 0xBEEF EOP, then valid packet [0x5 SOP EOP] -> first two beats dropped; err_count=1; single-beat packet delivered local.
- Second SOP [0x9] mid-local-packet -> err_count=1; 0x9 and following beats go forward.
- Reset asserted mid-packet with local register full -> next cycle all valids=0, counters=0; state IDLE.
